// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the CPU's
//   instruction fetch (IF stage) and data access (MEM stage). Each access is
//   sequenced with a req/ack handshake, and the comb stall outputs freeze the
//   pipeline until the access completes. Data access has fixed priority over
//   fetch. An optional timeout recovers from a memory that never acks.
//
// Parameters
//   ADDR_W, DATA_W   address / data width
//   TIMEOUT_CYCLES   max request cycles without ack (0 disables the timeout)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   if_req_i, if_addr_i          fetch request and PC
//   if_rdata_o, if_valid_o       fetched instruction and 1-cycle completion pulse
//   dm_read_i, dm_write_i        load / store request
//   dm_addr_i, dm_wdata_i        data address and store data
//   dm_rdata_o, dm_valid_o       load data and 1-cycle completion pulse
//   mem_req_o, mem_we_o          memory request (held until ack) and write enable
//   mem_addr_o, mem_wdata_o      registered memory address / write data
//   mem_ack_i, mem_rdata_i       memory completion and read data (same cycle)
//   if_stall_o, stall_mem_o      comb stalls for the IF stage / whole pipeline
//   err_o                        sticky timeout flag
//
// Optional build feature: define ARB_PERF_CNT_EN to add the 32-bit counters
//   fetch_cnt_o, data_cnt_o (completion pulses) and stall_cnt_o (stall cycles).
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_stall_o,
  output logic              stall_mem_o,
  output logic              err_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       data_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; the expiring cycle is
  // detected by comparison rather than by counting one further.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [DATA_W-1:0] RD_FILL  = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t            state_q;
  logic              if_valid_q, dm_valid_q, mem_req_q, mem_we_q, err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              data_pend;
  logic              tmo_hit;

  assign data_pend = dm_read_i | dm_write_i;
  assign tmo_hit   = (TIMEOUT_CYCLES > 0) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          // A stalled MEM stage blocks the whole pipeline, so data goes first.
          if (data_pend) begin
            state_q     <= DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_write_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
          end else if (if_req_i) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
          end
        end
        FETCH, DATA: begin
          // Ack beats a simultaneous timeout.
          if (mem_ack_i || tmo_hit) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (!mem_ack_i) begin
              err_q <= 1'b1;
            end
            if (state_q == FETCH) begin
              if_rdata_q <= mem_ack_i ? mem_rdata_i : RD_FILL;
              if_valid_q <= 1'b1;
            end else begin
              if (!mem_we_q) begin
                dm_rdata_q <= mem_ack_i ? mem_rdata_i : RD_FILL;
              end
              dm_valid_q <= 1'b1;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        RESP: begin
          // Request lines still belong to the completing instruction here,
          // so no grant is made in this cycle.
          if_valid_q <= 1'b0;
          dm_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_valid_o  = dm_valid_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

  // The completion pulse releases the stall in the same cycle it appears.
  assign if_stall_o  = if_req_i & ~if_valid_q;
  assign stall_mem_o = data_pend & ~dm_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, data_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      data_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (if_valid_q) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (dm_valid_q) begin
        data_cnt_q <= data_cnt_q + 32'd1;
      end
      if (if_stall_o | stall_mem_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign data_cnt_o  = data_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: CPU-side driver, memory responder with
// per-access ack delays, and a scoreboard monitor comparing each memory
// request and completion against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TMO = 4;
  localparam logic [31:0] FILL = 32'hDEADBEEF;

  logic        clk_i, rst_i;
  logic        if_req_i, dm_read_i, dm_write_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_valid_o, dm_valid_o, mem_req_o, mem_we_o;
  logic        if_stall_o, stall_mem_o, err_o;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, data_cnt_o, stall_cnt_o;
  int          stall_seen = 0;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .if_stall_o(if_stall_o), .stall_mem_o(stall_mem_o), .err_o(err_o)
`ifdef ARB_PERF_CNT_EN
    ,
    .fetch_cnt_o(fetch_cnt_o), .data_cnt_o(data_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] if_rd;
    logic [31:0] dm_rd;
    bit          err;
    int          len;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] rd;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;
  int inject_seq = 0;

  // Reference model state
  logic [31:0] m_if_rd, m_dm_rd;
  bit          m_err;
  int          m_nf, m_nd;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Model one access in service order; d is the ack delay in request cycles.
  task automatic push_op(input bit is_fetch, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input logic [31:0] rd);
    exp_t e;
    rsp_t r;
    bit   timed;
    timed = (d >= TMO);
    if (is_fetch) begin
      m_if_rd = timed ? FILL : rd;
      m_nf++;
    end else begin
      if (!we) m_dm_rd = timed ? FILL : rd;
      m_nd++;
    end
    m_err      = m_err | timed;
    e.is_fetch = is_fetch;
    e.we       = we;
    e.addr     = addr;
    e.wdata    = wdata;
    e.if_rd    = m_if_rd;
    e.dm_rd    = m_dm_rd;
    e.err      = m_err;
    e.len      = timed ? TMO : d + 1;
    exp_q.push_back(e);
    r.d  = d;
    r.rd = rd;
    rsp_q.push_back(r);
  endtask

  // Called and returns at posedge+1. Holds requests until their completion
  // pulse, like a stalled pipeline stage.
  task automatic run_op(input bit do_f, input bit do_d, input bit we,
                        input logic [31:0] faddr, input logic [31:0] daddr,
                        input logic [31:0] wdata, input int fd, input int dd,
                        input logic [31:0] frd, input logic [31:0] drd);
    bit fpend, dpend;
    int guard;
    if (do_d) push_op(1'b0, we, daddr, wdata, dd, drd);
    if (do_f) push_op(1'b1, 1'b0, faddr, 32'h0, fd, frd);
    if_req_i   = do_f;
    if_addr_i  = faddr;
    dm_read_i  = do_d & ~we;
    dm_write_i = do_d & we;
    dm_addr_i  = daddr;
    dm_wdata_i = wdata;
    fpend = do_f;
    dpend = do_d;
    guard = 0;
    while ((fpend || dpend) && guard < 40) begin
      @(negedge clk_i);
      guard++;
      if (dm_valid_o) dpend = 0;
      if (if_valid_o) fpend = 0;
      @(posedge clk_i);
      #1;
      if (!dpend) begin
        dm_read_i  = 0;
        dm_write_i = 0;
      end
      if (!fpend) if_req_i = 0;
    end
    if (fpend || dpend) begin
      fail_now("op_completion_timeout");
      if_req_i   = 0;
      dm_read_i  = 0;
      dm_write_i = 0;
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(9);
    return (r < 8) ? (r % 4) : (TMO + r - 8);
  endfunction

  task automatic rand_op();
    int sel;
    sel = $urandom_range(4);
    run_op(sel == 0 || sel >= 3, sel != 0, sel == 2 || sel == 4,
           $urandom, $urandom, $urandom, pick_delay(), pick_delay(), $urandom, $urandom);
    repeat ($urandom_range(2)) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Memory responder: acks the current request after its scheduled delay,
  // and throws spurious acks when no request is outstanding.
  initial begin : responder
    rsp_t cur;
    bit   busy;
    int   waited;
    int   seen;
    busy = 0; waited = 0; seen = 0;
    cur.d = 0; cur.rd = 0;
    mem_ack_i = 0;
    mem_rdata_i = 0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i   = 0;
      mem_rdata_i = $urandom;
      if (seen != inject_seq) begin
        seen = inject_seq;
        mem_ack_i = 1;
      end else if (mem_req_o) begin
        if (!busy) begin
          busy = 1;
          waited = 0;
          if (rsp_q.size() > 0) cur = rsp_q.pop_front();
          else begin
            cur.d = 1000;
            cur.rd = 0;
          end
        end
        if (waited == cur.d) begin
          mem_ack_i   = 1;
          mem_rdata_i = cur.rd;
        end
        waited++;
      end else begin
        busy = 0;
        if ($urandom_range(3) == 0) mem_ack_i = 1;
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    exp_t cur;
    bit   have;
    bit   prev_req;
    int   len;
    have = 0; prev_req = 0; len = 0;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        chk("if_stall", {31'b0, if_stall_o}, {31'b0, if_req_i & ~if_valid_o});
        chk("stall_mem", {31'b0, stall_mem_o}, {31'b0, (dm_read_i | dm_write_i) & ~dm_valid_o});
`ifdef ARB_PERF_CNT_EN
        if ((if_req_i & ~if_valid_o) | ((dm_read_i | dm_write_i) & ~dm_valid_o)) stall_seen++;
`endif
        if (mem_req_o && !prev_req) begin
          len = 0;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_req");
            have = 0;
          end else begin
            cur  = exp_q.pop_front();
            have = 1;
            chk("req_addr", mem_addr_o, cur.addr);
            chk("req_we", {31'b0, mem_we_o}, {31'b0, cur.we});
            if (cur.we) chk("req_wdata", mem_wdata_o, cur.wdata);
          end
        end
        if (mem_req_o) begin
          len++;
          if (have && len > 1) chk("addr_stable", mem_addr_o, cur.addr);
        end
        if (if_valid_o || dm_valid_o) begin
          if (!have) fail_now("unexpected_valid");
          else begin
            chk("resp_latency", {30'b0, prev_req, mem_req_o}, 32'd2);
            chk("req_cycles", len, cur.len);
            chk("if_valid", {31'b0, if_valid_o}, {31'b0, cur.is_fetch});
            chk("dm_valid", {31'b0, dm_valid_o}, {31'b0, !cur.is_fetch});
            chk("if_rdata", if_rdata_o, cur.if_rd);
            chk("dm_rdata", dm_rdata_o, cur.dm_rd);
            chk("err", {31'b0, err_o}, {31'b0, cur.err});
            have = 0;
          end
        end
        prev_req = mem_req_o;
      end
    end
  end

  initial begin : main
    int guard;
    m_if_rd = 0; m_dm_rd = 0; m_err = 0; m_nf = 0; m_nd = 0;
    rst_i = 1;
    if_req_i = 0; dm_read_i = 0; dm_write_i = 0;
    if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_dm_valid", {31'b0, dm_valid_o}, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i  = 0;
    mon_en = 1;

    // Fetch acked on the third request cycle
    run_op(1, 0, 0, 32'h10, 32'h0, 32'h0, 2, 0, 32'h20010005, 32'h0);
    // Fetch and load together: load is served first
    run_op(1, 1, 0, 32'h14, 32'h40, 32'h0, 1, 0, 32'h11112222, 32'h33334444);
    // Store acked in the first request cycle
    run_op(0, 1, 1, 32'h0, 32'h8, 32'hCAFE, 0, 0, 32'h0, 32'h5555AAAA);
    // Ack in the same cycle the timeout would fire
    run_op(0, 1, 0, 32'h0, 32'h20, 32'h0, 0, TMO - 1, 32'h0, 32'h0BADF00D);
    // No ack at all: timeout, filler data, sticky error
    run_op(0, 1, 0, 32'h0, 32'h24, 32'h0, 0, TMO + 1, 32'h0, 32'h12345678);
    run_op(1, 0, 0, 32'h18, 32'h0, 32'h0, 0, 0, 32'h87654321, 32'h0);

    for (int i = 0; i < 120; i++) rand_op();

    repeat (3) @(negedge clk_i);
    chk("exp_drained", exp_q.size(), 32'd0);
`ifdef ARB_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt_o, m_nf);
    chk("data_cnt", data_cnt_o, m_nd);
    chk("stall_cnt", stall_cnt_o, stall_seen);
`endif

    // Reset in the middle of a fetch, with an ack arriving after the reset
    mon_en = 0;
    @(posedge clk_i);
    #1;
    begin
      rsp_t r;
      r.d = 1000;
      r.rd = 32'hFFFF0000;
      rsp_q.push_back(r);
    end
    if_req_i  = 1;
    if_addr_i = 32'h100;
    guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while (!mem_req_o && guard < 10);
    if (!mem_req_o) fail_now("midreset_no_req");
    @(posedge clk_i);
    #1;
    rst_i = 1;
    @(negedge clk_i);
    inject_seq++;
    @(posedge clk_i);
    #1;
    rst_i    = 0;
    if_req_i = 0;
    m_if_rd = 0; m_dm_rd = 0; m_err = 0;
    @(negedge clk_i);
    chk("midrst_req", {31'b0, mem_req_o}, 32'd0);
    chk("midrst_err", {31'b0, err_o}, 32'd0);
    chk("midrst_if_rdata", if_rdata_o, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("midrst_no_valid", {31'b0, if_valid_o}, 32'd0);
      chk("midrst_req_low", {31'b0, mem_req_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    mon_en = 1;
    run_op(1, 0, 0, 32'h200, 32'h0, 32'h0, 1, 0, 32'hA5A5A5A5, 32'h0);
    repeat (3) @(negedge clk_i);
    chk("exp_drained_end", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
